// File: rtl/fifo_read_ctrl_if.sv
// Read-side bus of the asynchronous FIFO: the memory read port, the pointer exchange
// with the write domain, and the valid/ready output stage toward the consumer.
interface fifo_read_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] read_addr;
  logic              read_enable;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_count;

  modport master (
    input  wr_ptr_gray, mem_data, dout_ready,
    output read_addr, read_enable, rd_ptr_gray, dout, dout_valid,
           empty, almost_empty, rd_count
  );

  modport slave (
    output wr_ptr_gray, mem_data, dout_ready,
    input  read_addr, read_enable, rd_ptr_gray, dout, dout_valid,
           empty, almost_empty, rd_count
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the asynchronous FIFO: synchronises the write pointer,
// derives empty/almost_empty/rd_count and feeds a one-word valid/ready output register.
module fifo_read_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int AEMPTY_TH = 4
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             flush,
  fifo_read_ctrl_if.master bus
);
  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0]   wq1_q, wq2_q;
  logic [ADDR_W:0]   wq2_bin;
  logic [ADDR_W:0]   rd_bin_q, rd_bin_d;
  logic [ADDR_W:0]   rd_gray_q, rd_gray_d;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              clear;
  logic              empty;
  logic              pop;

  assign clear = !reset || flush;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    wq2_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wq2_bin[i] = ^(wq2_q >> i);
    end
  end

  assign empty = (rd_gray_q == wq2_q);
  assign count = wq2_bin - rd_bin_q;
  assign pop   = !clear && !empty && (!dout_valid_q || bus.dout_ready);

  assign rd_bin_d  = rd_bin_q + 1'b1;
  assign rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);

  always_ff @(posedge rd_clk) begin
    if (clear) begin
      wq1_q        <= '0;
      wq2_q        <= '0;
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wq1_q <= bus.wr_ptr_gray;
      wq2_q <= wq1_q;
      if (pop) begin
        dout_q       <= bus.mem_data;
        dout_valid_q <= 1'b1;
        rd_bin_q     <= rd_bin_d;
        rd_gray_q    <= rd_gray_d;
      end else if (bus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign bus.read_addr    = rd_bin_q[ADDR_W-1:0];
  assign bus.read_enable  = pop;
  assign bus.rd_ptr_gray  = rd_gray_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.empty        = empty;
  assign bus.almost_empty = (count <= PW'(AEMPTY_TH));
  assign bus.rd_count     = count;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a vector table for the basic handshake plus
// hand-written wrap, full-drain and flush sequences against a behavioural memory.
module tb_fifo_read_ctrl;
  logic rd_clk = 1'b0;
  logic reset  = 1'b0;
  logic flush  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [128];

  fifo_read_ctrl_if #(.DATA_W(32), .ADDR_W(7)) bus ();

  fifo_read_ctrl #(.DATA_W(32), .ADDR_W(7), .AEMPTY_TH(4)) dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus.master)
  );

  always #5 rd_clk = ~rd_clk;

  always_comb bus.mem_data = mem[bus.read_addr];

  typedef struct {
    logic        rst;
    logic        fl;
    logic [7:0]  wp;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    logic        eae;
    logic [7:0]  ecnt;
    logic        ere;
    logic [6:0]  eaddr;
    logic [7:0]  eg;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [7:0] gray(input int n);
    logic [7:0] b;
    b = n[7:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] word(input int i);
    return (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + i;
  endfunction

  task automatic applyStimulus(input logic rst, input logic fl, input logic [7:0] wp,
                               input logic rdy);
    @(negedge rd_clk);
    reset           = rst;
    flush           = fl;
    bus.wr_ptr_gray = wp;
    bus.dout_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks every output-stage field after a flush or reset has cleared the block.
  task automatic checkCleared(input string tag);
    checkOutput({tag, " dout_valid"}, 32'(bus.dout_valid), 32'd0);
    checkOutput({tag, " dout"}, bus.dout, 32'd0);
    checkOutput({tag, " rd_ptr_gray"}, 32'(bus.rd_ptr_gray), 32'h00);
    checkOutput({tag, " empty"}, 32'(bus.empty), 32'd1);
    checkOutput({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
    checkOutput({tag, " rd_count"}, 32'(bus.rd_count), 32'd0);
    checkOutput({tag, " read_enable"}, 32'(bus.read_enable), 32'd0);
  endtask

  // Loads one unconsumed word with ten more entries behind it, then clears it.
  task automatic flushSequence(input string tag, input logic rst);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, gray(11), 1'b0);
    tick();
    tick();
    tick();
    checkOutput({tag, " pre dout_valid"}, 32'(bus.dout_valid), 32'd1);
    checkOutput({tag, " pre rd_count"}, 32'(bus.rd_count), 32'd10);
    checkOutput({tag, " pre dout"}, bus.dout, word(0));
    applyStimulus(rst, 1'b1, 8'h00, 1'b1);
    #1;
    checkOutput({tag, " gated read_enable"}, 32'(bus.read_enable), 32'd0);
    tick();
    checkCleared(tag);
  endtask

  initial begin
    bool_init: begin
      bus.wr_ptr_gray = '0;
      bus.dout_ready  = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = word(i);
    end

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'd0, 1'b0, 7'd0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 8'd0, 1'b0, 7'd0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 8'd1, 1'b1, 7'd0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 32'hDEADBEEF,  1'b1, 1'b1, 8'd0, 1'b0, 7'd1, 8'h01};
    vecs[4]  = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 32'hDEADBEEF,  1'b1, 1'b1, 8'd0, 1'b0, 7'd1, 8'h01};
    vecs[5]  = '{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'd0, 1'b0, 7'd0, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 8'd0, 1'b0, 7'd0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 8'd2, 1'b1, 7'd0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 1'b1, 8'd1, 1'b0, 7'd1, 8'h01};
    vecs[9]  = '{1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 1'b1, 8'd1, 1'b0, 7'd1, 8'h01};
    vecs[10] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 32'h10000001,  1'b1, 1'b1, 8'd0, 1'b0, 7'd2, 8'h03};
    vecs[11] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 32'h10000001,  1'b1, 1'b1, 8'd0, 1'b0, 7'd2, 8'h03};

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].fl, vecs[v].wp, vecs[v].rdy);
      tick();
      checkOutput($sformatf("v%0d dout_valid", v), 32'(bus.dout_valid), 32'(vecs[v].ev));
      checkOutput($sformatf("v%0d dout", v), bus.dout, vecs[v].ed);
      checkOutput($sformatf("v%0d empty", v), 32'(bus.empty), 32'(vecs[v].ee));
      checkOutput($sformatf("v%0d almost_empty", v), 32'(bus.almost_empty), 32'(vecs[v].eae));
      checkOutput($sformatf("v%0d rd_count", v), 32'(bus.rd_count), 32'(vecs[v].ecnt));
      checkOutput($sformatf("v%0d read_enable", v), 32'(bus.read_enable), 32'(vecs[v].ere));
      checkOutput($sformatf("v%0d read_addr", v), 32'(bus.read_addr), 32'(vecs[v].eaddr));
      checkOutput($sformatf("v%0d rd_ptr_gray", v), 32'(bus.rd_ptr_gray), 32'(vecs[v].eg));
    end

    // Wrap: drain to rd_bin=127, then read two words across the address wrap.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, gray(127), 1'b1);
    begin
      int budget = 400;
      while (!(bus.rd_ptr_gray == 8'h40 && !bus.dout_valid) && budget > 0) begin
        tick();
        budget--;
      end
      checkOutput("wrap prefill timeout", 32'(budget > 0), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, gray(129), 1'b1);
    tick();
    checkOutput("wrap sync1 empty", 32'(bus.empty), 32'd1);
    tick();
    checkOutput("wrap sync2 empty", 32'(bus.empty), 32'd0);
    checkOutput("wrap sync2 rd_count", 32'(bus.rd_count), 32'd2);
    checkOutput("wrap sync2 read_enable", 32'(bus.read_enable), 32'd1);
    checkOutput("wrap sync2 read_addr", 32'(bus.read_addr), 32'd127);
    checkOutput("wrap sync2 rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'h40);
    tick();
    checkOutput("wrap pop1 dout", bus.dout, word(127));
    checkOutput("wrap pop1 dout_valid", 32'(bus.dout_valid), 32'd1);
    checkOutput("wrap pop1 rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'hC0);
    checkOutput("wrap pop1 read_addr", 32'(bus.read_addr), 32'd0);
    checkOutput("wrap pop1 rd_count", 32'(bus.rd_count), 32'd1);
    tick();
    checkOutput("wrap pop2 dout", bus.dout, word(0));
    checkOutput("wrap pop2 rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'hC1);
    checkOutput("wrap pop2 read_addr", 32'(bus.read_addr), 32'd1);
    checkOutput("wrap pop2 empty", 32'(bus.empty), 32'd1);
    tick();
    checkOutput("wrap drained dout_valid", 32'(bus.dout_valid), 32'd0);

    // Full drain of 128 entries at one word per cycle.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, gray(128), 1'b1);
    tick();
    tick();
    checkOutput("drain start rd_count", 32'(bus.rd_count), 32'd128);
    checkOutput("drain start almost_empty", 32'(bus.almost_empty), 32'd0);
    checkOutput("drain start read_enable", 32'(bus.read_enable), 32'd1);
    for (int k = 1; k <= 128; k++) begin
      tick();
      checkOutput($sformatf("drain%0d rd_count", k), 32'(bus.rd_count), 32'(128 - k));
      checkOutput($sformatf("drain%0d almost_empty", k), 32'(bus.almost_empty),
                  32'((128 - k) <= 4));
      checkOutput($sformatf("drain%0d dout_valid", k), 32'(bus.dout_valid), 32'd1);
      checkOutput($sformatf("drain%0d dout", k), bus.dout, word(k - 1));
    end
    checkOutput("drain end empty", 32'(bus.empty), 32'd1);
    checkOutput("drain end rd_ptr_gray", 32'(bus.rd_ptr_gray), 32'hC0);
    tick();
    checkOutput("drain end dout_valid", 32'(bus.dout_valid), 32'd0);

    flushSequence("flush", 1'b1);
    flushSequence("flush+reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
